btn_conditioner: RTL and testbench

- Multi-channel input conditioner for the game's push-button controls: left, right, up, down, attack and start.
- Sits between the board pins and game_top control logic on the 100 MHz system clock.
- Per channel:
  - synchronises the raw input and debounces it;
  - produces single-cycle press and release events;
  - optionally produces auto-repeat events while the button is held, for continuous movement and fire.
- Replaces per-button ad-hoc edge detection with one parametrised block.

---
 rtl/btn_conditioner.sv | 167 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: per-channel push-button conditioning for the game controls.
//
// Each channel independently synchronises its raw pin level, debounces it,
// emits one-cycle press/release strobes when the debounced level changes, and
// optionally emits auto-repeat strobes while the button stays held.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-high reset
//   btn_in        raw button levels (asynchronous to clk), active-high
//   repeat_en     per-channel auto-repeat enable (synchronous to clk)
//   level_out     debounced button level
//   press_pulse   one-cycle strobe in the first cycle level_out reads 1
//   release_pulse one-cycle strobe in the first cycle level_out reads 0
//   repeat_pulse  one-cycle auto-repeat strobe while held
//   action_pulse  press_pulse | repeat_pulse
module btn_conditioner #(
    parameter int N_CH            = 6,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 30000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic [N_CH-1:0] action_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HC_W   = $clog2(HC_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] DELAY_LAST  = HC_W'(REPEAT_DELAY - 1);
    localparam logic [HC_W-1:0] PERIOD_LAST = HC_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_e;

    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_d [SYNC_STAGES];
    logic [N_CH-1:0] sync_s;

    logic [DB_W-1:0] db_cnt_q [N_CH];
    logic [DB_W-1:0] db_cnt_d [N_CH];

    logic [N_CH-1:0] level_q, level_d;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] release_q, release_d;
    logic [N_CH-1:0] repeat_q, repeat_d;

    rpt_state_e      state_q [N_CH];
    rpt_state_e      state_d [N_CH];
    logic [HC_W-1:0] hc_q    [N_CH];
    logic [HC_W-1:0] hc_d    [N_CH];

    always_comb begin
        // Synchroniser chain: stage 0 samples the pin, last stage feeds debounce.
        sync_d[0] = btn_in;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sync_s = sync_q[SYNC_STAGES-1];

        // Debounce: count consecutive cycles that disagree with the accepted
        // level; any agreeing cycle restarts the count.
        for (int i = 0; i < N_CH; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = '0;
            if (sync_s[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync_s[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end

        // Edge strobes are registered so they line up with the level_out change.
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;

        // Repeat FSM looks at the next level so a release never coincides with
        // a repeat strobe, and a dropped enable suppresses the strobe at once.
        for (int i = 0; i < N_CH; i++) begin
            state_d[i]  = state_q[i];
            hc_d[i]     = hc_q[i];
            repeat_d[i] = 1'b0;
            if (!level_d[i] || !repeat_en[i]) begin
                state_d[i] = IDLE;
                hc_d[i]    = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        // Covers both a fresh press and enable rising while held.
                        state_d[i] = DELAY;
                        hc_d[i]    = '0;
                    end
                    DELAY: begin
                        if (hc_q[i] == DELAY_LAST) begin
                            repeat_d[i] = 1'b1;
                            hc_d[i]     = '0;
                            state_d[i]  = REPEAT;
                        end else begin
                            hc_d[i] = hc_q[i] + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (hc_q[i] == PERIOD_LAST) begin
                            repeat_d[i] = 1'b1;
                            hc_d[i]     = '0;
                        end else begin
                            hc_d[i] = hc_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        hc_d[i]    = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            for (int i = 0; i < N_CH; i++) begin
                db_cnt_q[i] <= '0;
                state_q[i]  <= IDLE;
                hc_q[i]     <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            state_q   <= state_d;
            hc_q      <= hc_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_out     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    // Both terms are flops, so this clears immediately on reset as well.
    assign action_pulse  = press_q | repeat_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: self-checking bench for btn_conditioner.
// Main instance uses N_CH=6, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; a second instance uses the minimum legal timing parameters.
module tb_btn_conditioner;

    localparam int N     = 6;
    localparam int S     = 2;
    localparam int DEB   = 4;
    localparam int RD    = 10;
    localparam int RP    = 3;
    localparam int HL    = S + DEB;
    localparam int TRACE = 4096;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0] btn_in, repeat_en;
    logic [N-1:0] level_out, press_pulse, release_pulse, repeat_pulse, action_pulse;
    logic [N-1:0] lvl_m, prs_m, rel_m, rpt_m, act_m;

    btn_conditioner #(
        .N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
        .level_out(level_out), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse),
        .action_pulse(action_pulse)
    );

    btn_conditioner #(
        .N_CH(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1),
        .REPEAT_DELAY(1), .REPEAT_PERIOD(1)
    ) dut_min (
        .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
        .level_out(lvl_m), .press_pulse(prs_m),
        .release_pulse(rel_m), .repeat_pulse(rpt_m),
        .action_pulse(act_m)
    );

    // ---------------- reference model ----------------
    // Level flips when the last DEB synchronised samples all disagree with it;
    // repeat strobes fall at ages RD, RD+RP, RD+2RP ... counted from arming.
    logic [N-1:0] hist [HL];
    logic [N-1:0] m_level, m_press, m_release, m_repeat, m_armed;
    int           m_age [N];
    logic [N-1:0] w_hi, w_lo, nxt_level, nxt_armed;

    always_comb begin
        w_hi = '1;
        w_lo = '1;
        for (int k = 1; k <= DEB; k++) begin
            w_hi = w_hi & hist[k];
            w_lo = w_lo & ~hist[k];
        end
        nxt_level = (m_level & ~w_lo) | (~m_level & w_hi);
        nxt_armed = nxt_level & repeat_en;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < HL; k++) hist[k] <= '0;
            m_level   <= '0;
            m_press   <= '0;
            m_release <= '0;
            m_repeat  <= '0;
            m_armed   <= '0;
            for (int i = 0; i < N; i++) m_age[i] <= 0;
        end else begin
            for (int k = 0; k < HL - 1; k++) hist[k] <= hist[k+1];
            hist[HL-1] <= btn_in;
            m_level   <= nxt_level;
            m_press   <= nxt_level & ~m_level;
            m_release <= ~nxt_level & m_level;
            m_armed   <= nxt_armed;
            for (int i = 0; i < N; i++) begin
                if (nxt_armed[i] && m_armed[i]) begin
                    m_age[i]    <= m_age[i] + 1;
                    m_repeat[i] <= ((m_age[i] + 1) >= RD) && (((m_age[i] + 1 - RD) % RP) == 0);
                end else begin
                    m_age[i]    <= 0;
                    m_repeat[i] <= 1'b0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    logic [N-1:0] tr_level [TRACE];
    logic [N-1:0] tr_press [TRACE];
    logic [N-1:0] tr_rel   [TRACE];
    logic [N-1:0] tr_rpt   [TRACE];
    logic [N-1:0] tr_act   [TRACE];
    logic [N-1:0] tr_lvl_m [TRACE];
    logic [N-1:0] tr_prs_m [TRACE];
    logic [N-1:0] tr_rel_m [TRACE];
    logic [N-1:0] tr_rpt_m [TRACE];
    logic [N-1:0] tr_act_m [TRACE];

    // Advance n cycles: sample/compare on each falling edge, return just after
    // the next rising edge so the caller can drive inputs.
    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (cyc < TRACE) begin
                tr_level[cyc] = level_out;
                tr_press[cyc] = press_pulse;
                tr_rel[cyc]   = release_pulse;
                tr_rpt[cyc]   = repeat_pulse;
                tr_act[cyc]   = action_pulse;
                tr_lvl_m[cyc] = lvl_m;
                tr_prs_m[cyc] = prs_m;
                tr_rel_m[cyc] = rel_m;
                tr_rpt_m[cyc] = rpt_m;
                tr_act_m[cyc] = act_m;
            end
            check($sformatf("model c%0d", cyc),
                  64'({level_out, press_pulse, release_pulse, repeat_pulse, action_pulse}),
                  64'({m_level, m_press, m_release, m_repeat, m_press | m_repeat}));
            check($sformatf("press_rpt_excl c%0d", cyc), 64'(press_pulse & repeat_pulse), 64'(0));
            @(posedge clk);
            #2;
        end
    endtask

    typedef struct {
        int   ch;
        int   off;
        logic lvl;
        logic prs;
        logic rel;
        logic rpt;
    } vec_t;

    function automatic vec_t mk(input int ch, input int off, input logic lvl,
                                input logic prs, input logic rel, input logic rpt);
        vec_t v;
        v.ch = ch; v.off = off; v.lvl = lvl; v.prs = prs; v.rel = rel; v.rpt = rpt;
        return v;
    endfunction

    task automatic apply_table(input string tag, input int t0, input vec_t tbl[$]);
        for (int k = 0; k < tbl.size(); k++) begin
            int c;
            int ch;
            c  = t0 + tbl[k].off;
            ch = tbl[k].ch;
            check($sformatf("%s ch%0d T+%0d level", tag, ch, tbl[k].off), 64'(tr_level[c][ch]), 64'(tbl[k].lvl));
            check($sformatf("%s ch%0d T+%0d press", tag, ch, tbl[k].off), 64'(tr_press[c][ch]), 64'(tbl[k].prs));
            check($sformatf("%s ch%0d T+%0d release", tag, ch, tbl[k].off), 64'(tr_rel[c][ch]), 64'(tbl[k].rel));
            check($sformatf("%s ch%0d T+%0d repeat", tag, ch, tbl[k].off), 64'(tr_rpt[c][ch]), 64'(tbl[k].rpt));
            check($sformatf("%s ch%0d T+%0d action", tag, ch, tbl[k].off), 64'(tr_act[c][ch]),
                  64'(tbl[k].prs | tbl[k].rpt));
        end
    endtask

    vec_t s1_tbl[$];
    vec_t s3_tbl[$];
    vec_t s4_tbl[$];
    vec_t s5_tbl[$];

    // ---------------- stimulus ----------------
    initial begin
        int t0;
        int cnt;
        logic [N-1:0] acc;

        assert (S >= 2 && DEB >= 1 && RD >= 1 && RP >= 1)
        else begin
            $display("FAIL params: illegal parameter set");
            $fatal(1);
        end

        // lvl, prs, rel, rpt expectations relative to the btn_in change edge T
        s1_tbl.push_back(mk(0,  5, 0, 0, 0, 0));
        s1_tbl.push_back(mk(0,  6, 1, 1, 0, 0));
        s1_tbl.push_back(mk(0,  7, 1, 0, 0, 0));
        s1_tbl.push_back(mk(0, 20, 1, 0, 0, 0));
        s1_tbl.push_back(mk(0, 45, 1, 0, 0, 0));
        s1_tbl.push_back(mk(0, 46, 0, 0, 1, 0));
        s1_tbl.push_back(mk(0, 47, 0, 0, 0, 0));

        s3_tbl.push_back(mk(4,  5, 0, 0, 0, 0));
        s3_tbl.push_back(mk(4,  6, 1, 1, 0, 0));
        s3_tbl.push_back(mk(4,  7, 1, 0, 0, 0));
        s3_tbl.push_back(mk(4, 15, 1, 0, 0, 0));
        s3_tbl.push_back(mk(4, 16, 1, 0, 0, 1));
        s3_tbl.push_back(mk(4, 17, 1, 0, 0, 0));
        s3_tbl.push_back(mk(4, 19, 1, 0, 0, 1));
        s3_tbl.push_back(mk(4, 22, 1, 0, 0, 1));
        s3_tbl.push_back(mk(4, 23, 1, 0, 0, 0));
        s3_tbl.push_back(mk(4, 24, 0, 0, 1, 0));
        s3_tbl.push_back(mk(4, 25, 0, 0, 0, 0));

        s4_tbl.push_back(mk(4,  6, 1, 1, 0, 0));
        s4_tbl.push_back(mk(4, 16, 1, 0, 0, 1));
        s4_tbl.push_back(mk(4, 19, 1, 0, 0, 0));
        s4_tbl.push_back(mk(4, 20, 1, 0, 0, 0));
        s4_tbl.push_back(mk(4, 29, 1, 0, 0, 0));
        s4_tbl.push_back(mk(4, 30, 1, 0, 0, 1));
        s4_tbl.push_back(mk(4, 33, 1, 0, 0, 1));
        s4_tbl.push_back(mk(4, 36, 1, 0, 0, 1));
        s4_tbl.push_back(mk(4, 45, 1, 0, 0, 1));
        s4_tbl.push_back(mk(4, 46, 0, 0, 1, 0));
        s4_tbl.push_back(mk(4, 47, 0, 0, 0, 0));

        s5_tbl.push_back(mk(2, 5, 0, 0, 0, 0));
        s5_tbl.push_back(mk(2, 6, 1, 1, 0, 0));
        s5_tbl.push_back(mk(2, 7, 1, 0, 0, 0));

        rst       = 1'b1;
        btn_in    = '0;
        repeat_en = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset level", 64'(level_out), 64'(0));
        check("reset press", 64'(press_pulse), 64'(0));
        check("reset release", 64'(release_pulse), 64'(0));
        check("reset repeat", 64'(repeat_pulse), 64'(0));
        check("reset action", 64'(action_pulse), 64'(0));
        rst = 1'b0;
        run(10);

        // 1: clean press and release, repeat disabled
        t0 = cyc;
        btn_in[0] = 1'b1;
        run(40);
        btn_in[0] = 1'b0;
        run(15);
        apply_table("clean", t0, s1_tbl);
        acc = '0;
        for (int c = t0; c < t0 + 55; c++) acc = acc | tr_rpt[c];
        check("clean no repeat", 64'(acc), 64'(0));
        check("min ch0 T+2 level", 64'(tr_lvl_m[t0+2][0]), 64'(0));
        check("min ch0 T+3 level", 64'(tr_lvl_m[t0+3][0]), 64'(1));
        check("min ch0 T+3 press", 64'(tr_prs_m[t0+3][0]), 64'(1));
        check("min ch0 T+4 press", 64'(tr_prs_m[t0+4][0]), 64'(0));
        check("min ch0 T+43 release", 64'(tr_rel_m[t0+43][0]), 64'(1));

        // 2: bounce with 3-cycle high segments is rejected
        t0 = cyc;
        btn_in[1] = 1'b1; run(3);
        btn_in[1] = 1'b0; run(2);
        btn_in[1] = 1'b1; run(3);
        btn_in[1] = 1'b0; run(20);
        acc = '0;
        for (int c = t0; c < t0 + 28; c++) acc = acc | tr_level[c];
        check("bounce level", 64'(acc), 64'(0));
        acc = '0;
        for (int c = t0; c < t0 + 28; c++) acc = acc | tr_press[c] | tr_rel[c] | tr_rpt[c] | tr_act[c];
        check("bounce pulses", 64'(acc), 64'(0));

        // 3: auto-repeat while held, then release
        repeat_en[4] = 1'b1;
        run(2);
        t0 = cyc;
        btn_in[4] = 1'b1;
        run(18);
        btn_in[4] = 1'b0;
        run(12);
        apply_table("repeat", t0, s3_tbl);
        cnt = 0;
        for (int c = t0; c < t0 + 30; c++) cnt += int'(tr_rpt[c][4]);
        check("repeat count", 64'(cnt), 64'(3));
        check("min ch4 T+3 press", 64'(tr_prs_m[t0+3][4]), 64'(1));
        check("min ch4 T+3 repeat", 64'(tr_rpt_m[t0+3][4]), 64'(0));
        check("min ch4 T+4 repeat", 64'(tr_rpt_m[t0+4][4]), 64'(1));
        check("min ch4 T+4 action", 64'(tr_act_m[t0+4][4]), 64'(1));
        check("min ch4 T+5 repeat", 64'(tr_rpt_m[t0+5][4]), 64'(1));
        check("min ch4 T+20 repeat", 64'(tr_rpt_m[t0+20][4]), 64'(1));
        check("min ch4 T+21 repeat", 64'(tr_rpt_m[t0+21][4]), 64'(0));
        check("min ch4 T+21 release", 64'(tr_rel_m[t0+21][4]), 64'(1));
        repeat_en[4] = 1'b0;
        run(5);

        // 4: repeat_en dropped and restored while held
        repeat_en[4] = 1'b1;
        t0 = cyc;
        btn_in[4] = 1'b1;
        run(16);
        repeat_en[4] = 1'b0;
        run(3);
        repeat_en[4] = 1'b1;
        run(21);
        btn_in[4] = 1'b0;
        run(12);
        apply_table("en_drop", t0, s4_tbl);
        cnt = 0;
        for (int c = t0; c < t0 + 52; c++) cnt += int'(tr_press[c][4]);
        check("en_drop press count", 64'(cnt), 64'(1));
        repeat_en[4] = 1'b0;
        run(5);

        // 5: asynchronous reset in the middle of a hold
        btn_in[2] = 1'b1;
        run(10);
        check("pre-reset level ch2", 64'(level_out[2]), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("async rst level", 64'(level_out), 64'(0));
        check("async rst press", 64'(press_pulse), 64'(0));
        check("async rst release", 64'(release_pulse), 64'(0));
        check("async rst repeat", 64'(repeat_pulse), 64'(0));
        check("async rst action", 64'(action_pulse), 64'(0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        t0 = cyc;
        run(10);
        apply_table("post_rst", t0, s5_tbl);
        btn_in[2] = 1'b0;
        run(12);

        // 6: simultaneous channels, no crosstalk
        t0 = cyc;
        btn_in[0] = 1'b1;
        btn_in[3] = 1'b1;
        run(2);
        btn_in[5] = 1'b1;
        run(12);
        check("multi T+5 press", 64'(tr_press[t0+5]), 64'(6'b000000));
        check("multi T+6 press", 64'(tr_press[t0+6]), 64'(6'b001001));
        check("multi T+7 press", 64'(tr_press[t0+7]), 64'(6'b000000));
        check("multi T+8 press", 64'(tr_press[t0+8]), 64'(6'b100000));
        check("multi T+9 press", 64'(tr_press[t0+9]), 64'(6'b000000));
        check("multi T+8 level", 64'(tr_level[t0+8]), 64'(6'b101001));
        acc = '0;
        for (int c = t0; c < t0 + 14; c++) acc = acc | tr_press[c] | tr_level[c];
        check("multi crosstalk", 64'(acc & 6'b010110), 64'(0));
        btn_in = '0;
        run(12);

        // randomized: fast toggling, then long holds so repeats occur
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 700; c++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, (ph == 0) ? 5 : 39) == 0) btn_in[i] = ~btn_in[i];
                    if ($urandom_range(0, 29) == 0) repeat_en[i] = ~repeat_en[i];
                end
                run(1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
